// File: rtl/lane_rotator.sv
// lane_rotator
//   Pipelined multi-lane barrel rotator. Each transaction carries LANES lanes
//   of WIDTH bits, a per-lane rotate amount, one direction bit shared by all
//   lanes, and an opaque tag. Stage k applies the 2^k rotation to every lane
//   whose shift bit k is set, so a transaction leaves after SW = log2(WIDTH)
//   register stages. The whole pipeline advances or holds as one unit.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      input transaction valid
//   in_ready      input accepted this cycle (pipeline advancing)
//   in_data       LANES*WIDTH, lane i at [i*WIDTH +: WIDTH]
//   in_shift      LANES*SW, rotate amount of lane i at [i*SW +: SW]
//   in_dir        0 = rotate left, 1 = rotate right
//   in_tag        opaque tag carried alongside the data
//   out_valid     output transaction valid
//   out_ready     downstream accepts the output
//   out_data      rotated lanes, same packing as in_data
//   out_tag       tag of the transaction on out_data
//   busy          any stage holds a valid transaction
module lane_rotator #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LANES = 5,
  parameter int unsigned TAGW  = 4,
  localparam int unsigned SW   = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES*SW-1:0]    in_shift,
  input  logic                   in_dir,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [TAGW-1:0]        out_tag,
  output logic                   busy
);

  // Stage registers.
  logic [SW-1:0]          st_valid;
  logic [LANES*WIDTH-1:0] st_data  [SW];
  logic [LANES*SW-1:0]    st_shift [SW];
  logic                   st_dir   [SW];
  logic [TAGW-1:0]        st_tag   [SW];

  // Stage inputs: stage 0 is fed from the ports, stage k from stage k-1.
  logic [LANES*WIDTH-1:0] src_data  [SW];
  logic [LANES*SW-1:0]    src_shift [SW];
  logic                   src_dir   [SW];
  logic [TAGW-1:0]        src_tag   [SW];
  logic [LANES*WIDTH-1:0] rot_data  [SW];

  logic adv;

  // Rotation by the fixed amount 2^k; amt never exceeds WIDTH/2, so both
  // shift distances stay in range.
  function automatic logic [WIDTH-1:0] rot_step(input logic [WIDTH-1:0] x,
                                                input int unsigned k,
                                                input logic dir);
    int unsigned amt;
    amt = 32'd1 << k;
    if (dir)
      return (x >> amt) | (x << (WIDTH - amt));
    else
      return (x << amt) | (x >> (WIDTH - amt));
  endfunction

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = st_valid[SW-1];
  assign out_data  = st_data[SW-1];
  assign out_tag   = st_tag[SW-1];
  assign busy      = |st_valid;

  always_comb begin
    src_data[0]  = in_data;
    src_shift[0] = in_shift;
    src_dir[0]   = in_dir;
    src_tag[0]   = in_tag;
    for (int unsigned k = 1; k < SW; k++) begin
      src_data[k]  = st_data[k-1];
      src_shift[k] = st_shift[k-1];
      src_dir[k]   = st_dir[k-1];
      src_tag[k]   = st_tag[k-1];
    end
  end

  // Stage k consumes only bit k of each lane's rotate amount; the full
  // amount still travels down the pipe so later stages can see their bit.
  always_comb begin
    logic [WIDTH-1:0] lane;
    for (int unsigned k = 0; k < SW; k++) begin
      rot_data[k] = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        lane = src_data[k][i*WIDTH +: WIDTH];
        if (src_shift[k][i*SW + k])
          lane = rot_step(lane, k, src_dir[k]);
        rot_data[k][i*WIDTH +: WIDTH] = lane;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      for (int unsigned k = 0; k < SW; k++) begin
        st_data[k]  <= '0;
        st_shift[k] <= '0;
        st_dir[k]   <= 1'b0;
        st_tag[k]   <= '0;
      end
    end else if (adv) begin
      // Unaccepted cycles enter as bubbles and ride the pipe as invalid.
      st_valid <= {st_valid[SW-2:0], in_valid & in_ready};
      for (int unsigned k = 0; k < SW; k++) begin
        st_data[k]  <= rot_data[k];
        st_shift[k] <= src_shift[k];
        st_dir[k]   <= src_dir[k];
        st_tag[k]   <= src_tag[k];
      end
    end
  end

endmodule
